// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N2 UART transmitter fed by a small byte FIFO.
// Queued bytes are sent LSB-first, back-to-back with no idle cell.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 196,
  parameter int STOP_BITS    = 2,
  parameter int FIFO_AW      = 2
) (
  input  logic       CLK_UART,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       transmit,
  output logic       tx,
  output logic       is_transmitting,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       tx_done,
  output logic       tx_overflow
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CYC_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic STOP_MAX = 1'(STOP_BITS - 1);
  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t             state;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   count_nxt;
  logic [7:0]         shreg;
  logic [7:0]         head;
  logic [CW-1:0]      cyc_cnt;
  logic [2:0]         bit_cnt;
  logic               stop_cnt;
  logic               cell_end;
  logic               frame_end;
  logic               push;
  logic               pop;

  always_comb begin
    cell_end  = (cyc_cnt == '0);
    frame_end = (state == S_STOP) && cell_end && !stop_cnt;
    push      = transmit && !tx_full;
    // A pop either starts from idle or chains onto the end of a frame
    pop       = !tx_empty && ((state == S_IDLE) || frame_end);
    head      = mem[rd_ptr];
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 1'b1;
    else if (pop && !push)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge CLK_UART) begin
    if (push && !rst)
      mem[wr_ptr] <= tx_byte;
  end

  always_ff @(posedge CLK_UART) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx_full     <= 1'b0;
      tx_empty    <= 1'b1;
      tx_overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count       <= count_nxt;
      tx_full     <= (count_nxt == CNT_FULL);
      tx_empty    <= (count_nxt == '0);
      tx_overflow <= transmit && tx_full;
    end
  end

  always_ff @(posedge CLK_UART) begin
    if (rst) begin
      state           <= S_IDLE;
      shreg           <= '0;
      cyc_cnt         <= '0;
      bit_cnt         <= '0;
      stop_cnt        <= 1'b0;
      tx              <= 1'b1;
      is_transmitting <= 1'b0;
      tx_done         <= 1'b0;
    end else begin
      tx_done         <= frame_end;
      is_transmitting <= (state != S_IDLE);
      unique case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shreg   <= head;
            cyc_cnt <= CYC_MAX;
            state   <= S_START;
          end
        end
        S_START: begin
          tx <= 1'b0;
          if (cell_end) begin
            bit_cnt <= 3'd7;
            cyc_cnt <= CYC_MAX;
            state   <= S_DATA;
          end else begin
            cyc_cnt <= cyc_cnt - 1'b1;
          end
        end
        S_DATA: begin
          tx <= shreg[0];
          if (cell_end) begin
            cyc_cnt <= CYC_MAX;
            shreg   <= {1'b0, shreg[7:1]};
            if (bit_cnt == '0) begin
              stop_cnt <= STOP_MAX;
              state    <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt - 1'b1;
          end
        end
        S_STOP: begin
          tx <= 1'b1;
          if (cell_end) begin
            cyc_cnt <= CYC_MAX;
            if (!stop_cnt) begin
              if (pop) begin
                shreg <= head;
                state <= S_START;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              stop_cnt <= 1'b0;
            end
          end else begin
            cyc_cnt <= cyc_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: three parameterisations of uart_tx_fifo checked
// cycle by cycle against a frame-timing model and a line receiver.
module tb_uart_tx_fifo;

  localparam int N     = 3;
  localparam int DEPTH = 4;

  logic clk;
  logic [N-1:0]      rst_v;
  logic [N-1:0]      trn_v;
  logic [N-1:0][7:0] byte_v;
  logic [N-1:0]      tx_w, it_w, full_w, empty_w, done_w, ovf_w;

  int compared;
  int mismatched;

  uart_tx_fifo u0 (
    .CLK_UART(clk), .rst(rst_v[0]), .tx_byte(byte_v[0]),
    .transmit(trn_v[0]), .tx(tx_w[0]), .is_transmitting(it_w[0]),
    .tx_full(full_w[0]), .tx_empty(empty_w[0]),
    .tx_done(done_w[0]), .tx_overflow(ovf_w[0])
  );

  uart_tx_fifo #(.CLKS_PER_BIT(4)) u1 (
    .CLK_UART(clk), .rst(rst_v[1]), .tx_byte(byte_v[1]),
    .transmit(trn_v[1]), .tx(tx_w[1]), .is_transmitting(it_w[1]),
    .tx_full(full_w[1]), .tx_empty(empty_w[1]),
    .tx_done(done_w[1]), .tx_overflow(ovf_w[1])
  );

  uart_tx_fifo #(.CLKS_PER_BIT(2), .STOP_BITS(1)) u2 (
    .CLK_UART(clk), .rst(rst_v[2]), .tx_byte(byte_v[2]),
    .transmit(trn_v[2]), .tx(tx_w[2]), .is_transmitting(it_w[2]),
    .tx_full(full_w[2]), .tx_empty(empty_w[2]),
    .tx_done(done_w[2]), .tx_overflow(ovf_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cpb_of(input int i);
    return (i == 0) ? 196 : (i == 1) ? 4 : 2;
  endfunction

  function automatic int sb_of(input int i);
    return (i == 2) ? 1 : 2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: a byte queue plus the absolute cycle at which the
  // current frame was popped; the line is a function of elapsed cycles.
  longint     cyc;
  logic [7:0] mq    [N][$];
  logic [7:0] mdone [N][$];
  logic [7:0] dec   [N][$];
  logic [7:0] exp_q [$];
  bit         busy  [N];
  longint     pe    [N];
  logic [7:0] cur   [N];
  bit         valid [N];
  bit         rx_clr[N];
  logic [N-1:0] e_tx, e_it, e_full, e_empty, e_done, e_ovf;

  task automatic model_step(input int i);
    int c, fl, pre_n, k;
    c  = cpb_of(i);
    fl = (9 + sb_of(i)) * c;
    if (rst_v[i]) begin
      mq[i].delete();
      busy[i]    = 0;
      e_tx[i]    = 1'b1;
      e_it[i]    = 1'b0;
      e_full[i]  = 1'b0;
      e_empty[i] = 1'b1;
      e_done[i]  = 1'b0;
      e_ovf[i]   = 1'b0;
      valid[i]   = 1;
      rx_clr[i]  = 1;
      return;
    end
    if (!valid[i]) return;
    pre_n = mq[i].size();
    if (busy[i] && cyc > pe[i] && cyc <= pe[i] + fl) begin
      k = int'((cyc - pe[i] - 1) / c);
      e_tx[i]   = (k == 0) ? 1'b0 : (k <= 8) ? cur[i][k-1] : 1'b1;
      e_it[i]   = 1'b1;
      e_done[i] = (cyc == pe[i] + fl);
    end else begin
      e_tx[i]   = 1'b1;
      e_it[i]   = 1'b0;
      e_done[i] = 1'b0;
    end
    if (busy[i] && cyc == pe[i] + fl) begin
      busy[i] = 0;
      mdone[i].push_back(cur[i]);
    end
    if (!busy[i] && pre_n > 0) begin
      cur[i]  = mq[i].pop_front();
      pe[i]   = cyc;
      busy[i] = 1;
    end
    e_ovf[i] = trn_v[i] && (pre_n == DEPTH);
    if (trn_v[i] && pre_n < DEPTH)
      mq[i].push_back(byte_v[i]);
    e_full[i]  = (mq[i].size() == DEPTH);
    e_empty[i] = (mq[i].size() == 0);
  endtask

  initial begin
    cyc = 0;
    for (int i = 0; i < N; i++) begin
      valid[i]  = 0;
      busy[i]   = 0;
      rx_clr[i] = 0;
      pe[i]     = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < N; i++) model_step(i);
    end
  end

  // Line receiver and event counters, sampled mid-cycle
  bit         rx_busy [N];
  int         rx_t    [N];
  logic [7:0] rx_b    [N];
  int         done_cnt[N];
  int         ovf_cnt [N];
  longint     it_first[N];
  longint     it_last [N];

  task automatic rx_step(input int i);
    int c, fl, s;
    c  = cpb_of(i);
    fl = (9 + sb_of(i)) * c;
    if (rx_clr[i]) begin
      rx_busy[i] = 0;
      rx_clr[i]  = 0;
    end
    if (!rx_busy[i]) begin
      if (tx_w[i] == 1'b0) begin
        rx_busy[i] = 1;
        rx_t[i]    = 0;
      end
    end else begin
      rx_t[i]++;
    end
    if (rx_busy[i]) begin
      if (rx_t[i] % c == c / 2) begin
        s = rx_t[i] / c;
        if (s == 0)
          chk($sformatf("rx%0d.start", i), tx_w[i], 0);
        else if (s <= 8)
          rx_b[i][s-1] = tx_w[i];
        else
          chk($sformatf("rx%0d.stop", i), tx_w[i], 1);
      end
      if (rx_t[i] == fl - 1) begin
        dec[i].push_back(rx_b[i]);
        rx_busy[i] = 0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rx_busy[i]  = 0;
      rx_t[i]     = 0;
      done_cnt[i] = 0;
      ovf_cnt[i]  = 0;
      it_first[i] = -1;
      it_last[i]  = -1;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (valid[i]) begin
          chk($sformatf("u%0d.tx", i), tx_w[i], e_tx[i]);
          chk($sformatf("u%0d.is_tx", i), it_w[i], e_it[i]);
          chk($sformatf("u%0d.full", i), full_w[i], e_full[i]);
          chk($sformatf("u%0d.empty", i), empty_w[i], e_empty[i]);
          chk($sformatf("u%0d.done", i), done_w[i], e_done[i]);
          chk($sformatf("u%0d.ovf", i), ovf_w[i], e_ovf[i]);
          rx_step(i);
          if (done_w[i] === 1'b1) done_cnt[i]++;
          if (ovf_w[i] === 1'b1) ovf_cnt[i]++;
          if (it_w[i] === 1'b1) begin
            if (it_first[i] < 0) it_first[i] = cyc;
            it_last[i] = cyc;
          end
        end
      end
    end
  end

  task automatic clr(input int i);
    dec[i].delete();
    mdone[i].delete();
    exp_q.delete();
    done_cnt[i] = 0;
    ovf_cnt[i]  = 0;
    it_first[i] = -1;
    it_last[i]  = -1;
  endtask

  task automatic chk_dec(input int i, input string nm);
    chk({nm, ".count"}, dec[i].size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < dec[i].size(); j++)
      chk($sformatf("%s.byte%0d", nm, j), dec[i][j], exp_q[j]);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic       ln [0:2200];
  int         done_e, fall_e, nhigh, d1, d2;
  logic       prev_it;
  logic [7:0] pat;
  logic [19:0] seqv;
  logic [7:0] rb;

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_v  = '1;
    trn_v  = '0;
    byte_v = '0;
    step(3);
    rst_v = '0;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("reset%0d.tx", i), tx_w[i], 1);
      chk($sformatf("reset%0d.is_tx", i), it_w[i], 0);
      chk($sformatf("reset%0d.empty", i), empty_w[i], 1);
      chk($sformatf("reset%0d.full", i), full_w[i], 0);
    end
    step(2);

    // Single byte 0x48 at default rate; edge 0 is the write edge
    clr(0);
    trn_v[0] = 1'b1;
    byte_v[0] = 8'h48;
    @(negedge clk);
    trn_v[0] = 1'b0;
    done_e = -1;
    fall_e = -1;
    prev_it = 1'b0;
    for (int e = 1; e <= 2200; e++) begin
      @(negedge clk);
      ln[e] = tx_w[0];
      if (done_w[0] === 1'b1) done_e = e;
      if (prev_it && !it_w[0] && fall_e < 0) fall_e = e;
      prev_it = it_w[0];
    end
    chk("single.idle_e1", ln[1], 1);
    chk("single.start_e2", ln[2], 0);
    chk("single.start_e197", ln[197], 0);
    pat = 8'b0100_1000;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("single.bit%0d_first", k), ln[198 + 196 * k], pat[k]);
      chk($sformatf("single.bit%0d_last", k), ln[393 + 196 * k], pat[k]);
    end
    nhigh = 0;
    for (int e = 1766; e <= 2157; e++) if (ln[e] === 1'b1) nhigh++;
    chk("single.stop_cycles", nhigh, 392);
    chk("single.done_edge", done_e, 2157);
    chk("single.done_cnt", done_cnt[0], 1);
    chk("single.is_tx_fall", fall_e, 2158);
    exp_q = '{8'h48};
    chk_dec(0, "single");

    // Burst of four, CLKS_PER_BIT=4
    clr(1);
    exp_q = '{8'h03, 8'h01, 8'h0C, 8'h02};
    for (int j = 0; j < 4; j++) begin
      trn_v[1] = 1'b1;
      byte_v[1] = exp_q[j];
      @(negedge clk);
    end
    trn_v[1] = 1'b0;
    step(4 * 44 + 20);
    chk("burst.ovf", ovf_cnt[1], 0);
    chk("burst.done_cnt", done_cnt[1], 4);
    chk("burst.span", int'(it_last[1] - it_first[1] + 1), 176);
    chk_dec(1, "burst");

    // Overflow: 0xA0..0xA5 on consecutive edges 0..5
    clr(1);
    for (int j = 0; j < 6; j++) begin
      if (j == 4) chk("ovf.full_e3", full_w[1], 0);
      if (j == 5) chk("ovf.full_e4", full_w[1], 1);
      trn_v[1] = 1'b1;
      byte_v[1] = 8'hA0 + 8'(j);
      @(negedge clk);
    end
    trn_v[1] = 1'b0;
    chk("ovf.pulse_e5", ovf_w[1], 1);
    step(5 * 44 + 20);
    chk("ovf.ovf_cnt", ovf_cnt[1], 1);
    chk("ovf.done_cnt", done_cnt[1], 5);
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    chk_dec(1, "ovf");

    // Reset during data bit 3 of 0x55 with 0xAA queued
    clr(1);
    trn_v[1] = 1'b1;
    byte_v[1] = 8'h55;
    @(negedge clk);
    byte_v[1] = 8'hAA;
    @(negedge clk);
    trn_v[1] = 1'b0;
    step(17);
    chk("rst.bit3", tx_w[1], 0);
    rst_v[1] = 1'b1;
    @(negedge clk);
    rst_v[1] = 1'b0;
    chk("rst.tx", tx_w[1], 1);
    chk("rst.empty", empty_w[1], 1);
    step(100);
    chk("rst.no_done", done_cnt[1], 0);
    chk("rst.no_frames", dec[1].size(), 0);
    trn_v[1] = 1'b1;
    byte_v[1] = 8'h0F;
    @(negedge clk);
    trn_v[1] = 1'b0;
    step(60);
    chk("rst.after_done", done_cnt[1], 1);
    exp_q = '{8'h0F};
    chk_dec(1, "rst.after");

    // One stop bit, CLKS_PER_BIT=2: 0xFF then 0x00
    clr(2);
    trn_v[2] = 1'b1;
    byte_v[2] = 8'hFF;
    @(negedge clk);
    byte_v[2] = 8'h00;
    @(negedge clk);
    trn_v[2] = 1'b0;
    d1 = -1;
    d2 = -1;
    for (int e = 2; e <= 45; e++) begin
      @(negedge clk);
      ln[e] = tx_w[2];
      if (done_w[2] === 1'b1) begin
        if (d1 < 0) d1 = e;
        else d2 = e;
      end
    end
    seqv = 20'b0_11111111_1_0_00000000_1;
    for (int k = 0; k < 20; k++)
      for (int m = 0; m < 2; m++)
        chk($sformatf("sb1.cell%0d_%0d", k, m), ln[2 + 2 * k + m], seqv[19 - k]);
    chk("sb1.idle_after", ln[42], 1);
    chk("sb1.done1", d1, 21);
    chk("sb1.done2", d2, 41);
    exp_q = '{8'hFF, 8'h00};
    chk_dec(2, "sb1");

    // Ten writes one frame apart; pointers wrap past depth 4
    clr(1);
    for (int j = 0; j < 10; j++) begin
      rb = 8'($urandom);
      exp_q.push_back(rb);
      trn_v[1] = 1'b1;
      byte_v[1] = rb;
      @(negedge clk);
      trn_v[1] = 1'b0;
      step(43);
    end
    step(60);
    chk("wrap.done_cnt", done_cnt[1], 10);
    chk("wrap.ovf", ovf_cnt[1], 0);
    chk_dec(1, "wrap");

    // Random writes and occasional resets
    for (int i = 1; i < N; i++) begin
      clr(i);
      for (int t = 0; t < 600; t++) begin
        rst_v[i]  = ($urandom_range(0, 199) == 0);
        trn_v[i]  = ($urandom_range(0, 3) == 0);
        byte_v[i] = 8'($urandom);
        @(negedge clk);
      end
      rst_v[i] = 1'b0;
      trn_v[i] = 1'b0;
      step((DEPTH + 2) * (9 + sb_of(i)) * cpb_of(i) + 20);
      exp_q = mdone[i];
      chk_dec(i, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
